// File: rtl/led_history_ram.sv
// led_history_ram: circular capture buffer for done-qualified LED samples, read back by age.
// Inputs from the divided-clock domain are synchronised; the RAM is inferred as block RAM.
module led_history_ram #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int OVERWRITE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_miss,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic                  wr_pulse
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [2:0]            done_q, done_d;
    logic [DATA_WIDTH-1:0] din1_q, din1_d, din2_q, din2_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic                  rd_en1_q, rd_en1_d;
    logic                  rd_miss1_q, rd_miss1_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_miss_q, rd_miss_d;
    logic                  edge_det, at_full, wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        done_d     = {done_q[1:0], done_in};
        din1_d     = data_in;
        din2_d     = din1_q;
        edge_det   = done_q[1] & ~done_q[2];
        at_full    = count_q == DEPTH_C;
        // clear swallows a coincident edge; the synchroniser history still advances
        wr_en      = edge_det & ~clear & (~at_full | (OVERWRITE != 0));
        wr_ptr_d   = clear ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_en);
        count_d    = clear ? '0 : count_q + (ADDR_WIDTH + 1)'(wr_en & ~at_full);
        overflow_d = ~clear & (overflow_q | (edge_det & at_full & (OVERWRITE == 0)));
        full_d     = count_d == DEPTH_C;
        wr_pulse_d = wr_en;
        // oldest entry sits at wr_ptr - count; at DEPTH the low bits of count are zero
        rd_addr    = wr_ptr_q - count_q[ADDR_WIDTH-1:0] + rd_idx;
        rd_en1_d   = rd_en;
        rd_miss1_d = {1'b0, rd_idx} >= count_q;
        rd_valid_d = rd_en1_q;
        rd_miss_d  = rd_en1_q & rd_miss1_q;
        rd_data_d  = rd_en1_q ? (rd_miss1_q ? '0 : ram_q) : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din2_q;
        if (rd_en) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= '0;
            din1_q     <= '0;
            din2_q     <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            rd_en1_q   <= 1'b0;
            rd_miss1_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_miss_q  <= 1'b0;
        end else begin
            done_q     <= done_d;
            din1_q     <= din1_d;
            din2_q     <= din2_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            wr_pulse_q <= wr_pulse_d;
            rd_en1_q   <= rd_en1_d;
            rd_miss1_q <= rd_miss1_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_miss_q  <= rd_miss_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_miss  = rd_miss_q;
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_led_history_ram.sv
// tb_led_history_ram: directed checks of capture timing, wrap/overflow policy, clear and reset.
module tb_led_history_ram;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] done = '0;
    logic [3:0] data_in = '0;
    logic       clear = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_idx = '0;
    logic [3:0] rd_data_a, rd_data_b, rd_data_c;
    logic       rd_valid_a, rd_valid_b, rd_valid_c;
    logic       rd_miss_a, rd_miss_b, rd_miss_c;
    logic [8:0] count_a;
    logic [2:0] count_b, count_c;
    logic       full_a, full_b, full_c;
    logic       overflow_a, overflow_b, overflow_c;
    logic       wr_pulse_a, wr_pulse_b, wr_pulse_c;
    int         checks = 0, errors = 0;
    int         pa = 0, pb = 0, pc = 0, p0;

    always #5 clk = ~clk;

    led_history_ram #(.DATA_WIDTH(4), .ADDR_WIDTH(8), .OVERWRITE(0)) u_a (
        .clk(clk), .rst(rst), .done_in(done[0]), .data_in(data_in), .clear(clear),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .rd_miss(rd_miss_a), .count(count_a), .full(full_a), .overflow(overflow_a),
        .wr_pulse(wr_pulse_a));

    led_history_ram #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .OVERWRITE(0)) u_b (
        .clk(clk), .rst(rst), .done_in(done[1]), .data_in(data_in), .clear(clear),
        .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_miss(rd_miss_b), .count(count_b), .full(full_b), .overflow(overflow_b),
        .wr_pulse(wr_pulse_b));

    led_history_ram #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .OVERWRITE(1)) u_c (
        .clk(clk), .rst(rst), .done_in(done[2]), .data_in(data_in), .clear(clear),
        .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .rd_miss(rd_miss_c), .count(count_c), .full(full_c), .overflow(overflow_c),
        .wr_pulse(wr_pulse_c));

    always @(negedge clk) begin
        pa += int'(wr_pulse_a);
        pb += int'(wr_pulse_b);
        pc += int'(wr_pulse_c);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] m, input logic [3:0] v);
        @(negedge clk) data_in = v;
        repeat (3) @(negedge clk);
        done = m;
        repeat (4) @(negedge clk);
        done = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] i);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_idx = i;
        @(negedge clk) rd_en = 1'b0;
        @(posedge clk) #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", count_a, 0);
        check("rst_flags", {full_a, overflow_a, wr_pulse_a, rd_valid_a, rd_miss_a}, 0);
        check("rst_data", rd_data_a, 0);

        @(negedge clk) data_in = 4'd1;
        repeat (3) @(negedge clk);
        done = 3'b001;
        @(posedge clk) #1 check("lat_n", wr_pulse_a, 0);
        @(posedge clk) #1 check("lat_n1", wr_pulse_a, 0);
        @(posedge clk) #1 check("lat_n2", wr_pulse_a, 1);
        check("lat_n2_count", count_a, 1);
        @(posedge clk) #1 check("lat_n3", wr_pulse_a, 0);
        @(negedge clk) done = '0;
        repeat (3) @(negedge clk);
        pulse(3'b001, 4'd2);
        pulse(3'b001, 4'd3);
        check("wr_cnt3", pa, 3);
        check("count3", count_a, 3);
        for (int i = 0; i < 3; i++) begin
            rd(8'(i));
            check("rd_valid", rd_valid_a, 1);
            check("rd_miss", rd_miss_a, 0);
            check("rd_data", rd_data_a, i + 1);
        end
        rd(8'd3);
        check("miss_valid", rd_valid_a, 1);
        check("miss_flag", rd_miss_a, 1);
        check("miss_data", rd_data_a, 0);
        @(posedge clk) #1 check("rd_fall", rd_valid_a, 0);

        p0 = pa;
        @(negedge clk) data_in = 4'd4;
        repeat (3) @(negedge clk);
        done = 3'b001;
        repeat (1000) @(negedge clk);
        done = '0;
        repeat (3) @(negedge clk);
        check("hold_writes", pa - p0, 1);
        check("hold_count", count_a, 4);

        for (int v = 1; v <= 5; v++) pulse(3'b110, 4'(v));
        pulse(3'b100, 4'd6);
        check("b_count", count_b, 4);
        check("b_full", full_b, 1);
        check("b_overflow", overflow_b, 1);
        check("b_writes", pb, 4);
        check("c_count", count_c, 4);
        check("c_full", full_c, 1);
        check("c_overflow", overflow_c, 0);
        check("c_writes", pc, 6);
        for (int i = 0; i < 4; i++) begin
            rd(8'(i));
            check("b_rd", rd_data_b, i + 1);
            check("c_rd", rd_data_c, i + 3);
            check("bc_miss", {rd_miss_b, rd_miss_c}, 0);
        end

        p0 = pb;
        @(negedge clk) data_in = 4'd7;
        repeat (3) @(negedge clk);
        done = 3'b010;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(posedge clk) #1;
        check("clr_pulse", wr_pulse_b, 0);
        check("clr_count", count_b, 0);
        check("clr_overflow", overflow_b, 0);
        check("clr_full", full_b, 0);
        @(negedge clk) clear = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_hold", count_b, 0);
        check("clr_writes", pb - p0, 0);
        done = '0;
        repeat (3) @(negedge clk);
        pulse(3'b010, 4'd9);
        rd(8'd0);
        check("clr_rd", rd_data_b, 9);
        check("clr_rd_miss", rd_miss_b, 0);
        check("clr_count1", count_b, 1);

        @(negedge clk) data_in = 4'd5;
        repeat (3) @(negedge clk);
        done = 3'b001;
        p0 = pa;
        @(posedge clk);
        @(posedge clk) #2 rst = 1'b1;
        #1;
        check("arst_count", count_a, 0);
        check("arst_flags", {full_a, overflow_a, wr_pulse_a, rd_valid_a, rd_miss_a}, 0);
        check("arst_count_b", count_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rel_n2", wr_pulse_a, 0);
        @(posedge clk) #1 check("rel_n3", wr_pulse_a, 1);
        repeat (6) @(negedge clk);
        check("rel_writes", pa - p0, 1);
        check("rel_count", count_a, 1);
        done = '0;
        rd(8'd0);
        check("rel_rd", rd_data_a, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_history_ram.md
# led_history_ram

Capture-and-replay history buffer that sits directly downstream of the go/done LED-counter stage. Each rising edge of that stage's done signal records its 4-bit LED value into an inferred iCE40 block RAM, organised as a circular buffer. A synchronous read port returns entries by age, oldest first. The block runs on the 12 MHz system clock; done and LED arrive from the divided-clock domain and are synchronised here.

## Interface
- DATA_WIDTH, 4, width of each captured sample
- ADDR_WIDTH, 8, RAM address width; DEPTH = 2^ADDR_WIDTH entries
- OVERWRITE, 0, 0 = drop new samples when full and flag overflow; 1 = overwrite the oldest entry
- clk  in  1  12 MHz system clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous and active-high
- done_in  in  1  done level from the upstream stage; asynchronous to clk
- data_in  in  DATA_WIDTH  LED value from the upstream stage; asynchronous to clk, quasi-static
- clear  in  1  synchronous clear of pointers, count and overflow; RAM contents are not cleared
- rd_en  in  1  single-cycle read request
- rd_idx  in  ADDR_WIDTH  age index of the read; 0 = oldest stored entry
- rd_data  out  DATA_WIDTH  read result, registered
- rd_valid  out  1  one-cycle pulse marking rd_data valid
- rd_miss  out  1  qualifies rd_valid; high when rd_idx >= count
- count  out  ADDR_WIDTH+1  number of stored entries, range 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky; set when a sample is dropped (OVERWRITE=0 only)
- wr_pulse  out  1  one-cycle pulse on every committed write

## Operation
- Synchroniser: done_in passes through a 2-flop chain (d1, d2) plus a history flop d3. The edge condition is d2 & ~d3. data_in passes through a parallel 2-flop chain.
- Data stability: data_in must be stable for at least 3 clk before done_in rises. The captured value is the data_in chain output on the cycle the edge is detected.
- On an edge with count < DEPTH:
  - RAM[wr_ptr] <= data
  - wr_ptr <= wr_ptr + 1, modulo DEPTH (wraps DEPTH-1 -> 0)
  - count <= count + 1
  - wr_pulse = 1
- On an edge with count == DEPTH and OVERWRITE=1:
  - the write proceeds and wr_ptr advances
  - count holds at DEPTH
  - the oldest entry is lost; wr_pulse = 1
- On an edge with count == DEPTH and OVERWRITE=0:
  - no write; wr_ptr and count are unchanged
  - overflow <= 1; wr_pulse stays 0
- Reads:
  - physical address = (wr_ptr - count + rd_idx) mod DEPTH, using ADDR_WIDTH-bit wrap arithmetic
  - if rd_idx >= count, rd_miss = 1 and rd_data = 0; the RAM output is ignored
- Read/write collision: a read and a write to the same physical address in the same cycle is read-before-write; rd_data returns the old contents.
- clear:
  - wr_ptr, count and overflow return to 0
  - the synchroniser keeps running
  - clear overrides a simultaneous edge, which is discarded with no write and no wr_pulse
  - a simultaneous rd_en is still serviced against the pre-clear count and pointer
- Reset sets every flop to 0: synchroniser chains, wr_ptr, count, overflow, rd_data, rd_valid, rd_miss and wr_pulse. RAM contents are undefined.
- Reset mid-write: any in-flight edge is lost. After release, done_in is re-synchronised from 0. If done_in is already high at release, that counts as a new edge about 3 clk later.

## Timing
- Write latency:
  - done_in is first sampled high at clk edge N
  - the write commits at edge N+2
  - count, full and wr_pulse update at edge N+2
  - wr_pulse is high for exactly one cycle (N+2 to N+3)
- Capture rate: at most one capture per done_in high period. A level held high for any duration produces exactly one write.
- Minimum done_in low time between captures: 2 clk.
- Read latency:
  - rd_en sampled at edge M -> rd_data, rd_valid and rd_miss valid after edge M+1
  - rd_valid falls after edge M+2 unless rd_en is asserted again
- Back-to-back rd_en on every cycle gives one result per cycle.
- full and count are registered outputs with no combinational path from the inputs.

## Test plan
- Reset, then 3 done_in pulses carrying data 1, 2, 3:
  - wr_pulse fires 3 times, each 2 clk after first sampling
  - count = 3
  - reads of idx 0, 1, 2 return 1, 2, 3 with rd_miss = 0
  - read of idx 3 returns rd_miss = 1, rd_data = 0
- Level hold: done_in held high for 1000 clk -> exactly one write; count increments by 1.
- With OVERWRITE=0 and ADDR_WIDTH=2:
  - 5 pulses carrying 1..5 -> full = 1, count = 4, overflow = 1
  - idx 0..3 read back 1, 2, 3, 4
- With OVERWRITE=1 and ADDR_WIDTH=2:
  - 6 pulses carrying 1..6 -> count = 4, overflow = 0, wr_ptr wrapped
  - idx 0..3 read back 3, 4, 5, 6
- clear coinciding with a detected edge:
  - no wr_pulse; count = 0, overflow = 0
  - the next pulse carrying 9 reads back as 9 at idx 0
- Async rst asserted between the first sampling edge and the commit edge:
  - all outputs go to 0 immediately
  - no write occurs
  - after release with done_in still high, exactly one write follows about 3 clk later
